ysyx_23060096_ifu: RTL

Instruction fetch unit that sits directly upstream of the single-cycle core datapath. It owns the fetch PC, issues one outstanding instruction-memory request at a time over a valid/ready request/response pair, and presents each fetched instruction with its PC to the decode stage over a valid/ready handshake. Execute-stage redirects (branches, jumps) override sequential PC+4 fetch and squash any in-flight or held instruction.

---
 rtl/ysyx_23060096_ifu.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060096_ifu.sv
// ysyx_23060096_ifu : instruction fetch unit.
// Owns the fetch PC and keeps at most one instruction-memory request
// outstanding. Each fetched word is held for decode until it is consumed.
// A redirect from execute replaces the fetch PC and squashes whatever
// instruction is in flight or being held.
//
// Optional feature: define YSYX_23060096_IFU_EBREAK_HALT_EN to make fetch stop
// for good once an ebreak has been handed to decode. Only reset leaves that
// state.
//
// state  | meaning
// INIT   | reset just released; no request on the bus yet
// REQ    | request on the bus, held until the memory accepts it
// WAIT   | waiting for the response to the outstanding request
// HOLD   | fetched instruction offered to decode
// HALT   | ebreak consumed; fetch stopped (only with the macro defined)

module ysyx_23060096_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    output logic        imem_rsp_ready,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef YSYX_23060096_IFU_EBREAK_HALT_EN
    localparam logic [31:0] EBREAK = 32'h0010_0073;
`endif

`ifdef YSYX_23060096_IFU_EBREAK_HALT_EN
    typedef enum logic [2:0] {S_INIT, S_REQ, S_WAIT, S_HOLD, S_HALT} state_e;
`else
    typedef enum logic [2:0] {S_INIT, S_REQ, S_WAIT, S_HOLD} state_e;
`endif

    state_e      state_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] req_addr_q;
    logic        kill_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        inst_fault_q;

    logic [31:0] redir_pc_d;
    logic [31:0] pc_plus4_d;

    // Redirect targets are forced word aligned; sequential fetch wraps naturally.
    assign redir_pc_d = redirect_pc & ~32'h0000_0003;
    assign pc_plus4_d = fetch_pc_q + 32'd4;

    // Fetch FSM with its PC, kill flag and held-instruction registers.
    // req_addr_q is separate from fetch_pc_q so a redirect can retarget the
    // next fetch while an unaccepted request keeps its address on the bus.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_INIT;
            fetch_pc_q   <= RESET_PC;
            req_addr_q   <= RESET_PC;
            kill_q       <= 1'b0;
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
            inst_fault_q <= 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    state_q <= S_REQ;
                    if (redirect_valid) begin
                        fetch_pc_q <= redir_pc_d;
                        req_addr_q <= redir_pc_d;
                    end else begin
                        req_addr_q <= fetch_pc_q;
                    end
                end
                S_REQ: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redir_pc_d;
                        kill_q     <= 1'b1;
                    end
                    if (imem_req_ready) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill_q || redirect_valid) begin
                            // Stale response: drop it and refetch from the target.
                            kill_q  <= 1'b0;
                            state_q <= S_REQ;
                            if (redirect_valid) begin
                                fetch_pc_q <= redir_pc_d;
                                req_addr_q <= redir_pc_d;
                            end else begin
                                req_addr_q <= fetch_pc_q;
                            end
                        end else begin
                            state_q      <= S_HOLD;
                            inst_q       <= imem_rsp_err ? NOP : imem_rsp_data;
                            inst_fault_q <= imem_rsp_err;
                            inst_pc_q    <= fetch_pc_q;
                        end
                    end else if (redirect_valid) begin
                        fetch_pc_q <= redir_pc_d;
                        kill_q     <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        state_q    <= S_REQ;
                        fetch_pc_q <= redir_pc_d;
                        req_addr_q <= redir_pc_d;
                    end else if (inst_ready) begin
                        fetch_pc_q <= pc_plus4_d;
                        req_addr_q <= pc_plus4_d;
`ifdef YSYX_23060096_IFU_EBREAK_HALT_EN
                        state_q    <= (inst_q == EBREAK) ? S_HALT : S_REQ;
`else
                        state_q    <= S_REQ;
`endif
                    end
                end
`ifdef YSYX_23060096_IFU_EBREAK_HALT_EN
                S_HALT: begin
                    state_q <= S_HALT;
                end
`endif
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    // Handshake outputs decode from state only; redirect masks inst_valid so a
    // squashed instruction can never be consumed in the redirect cycle.
    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = req_addr_q;
    assign imem_rsp_ready = (state_q == S_WAIT);
    assign inst_valid     = (state_q == S_HOLD) && !redirect_valid;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign inst_fault     = inst_fault_q;
`ifdef YSYX_23060096_IFU_EBREAK_HALT_EN
    assign halted         = (state_q == S_HALT);
`else
    assign halted         = 1'b0;
`endif

endmodule
